// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and address multiplexer
// for the 8-bit RISC core. It assembles each 2*DW-bit instruction from two
// consecutive memory bytes, high byte first, and presents the opcode and
// operand address to the cycle controller and the memory bus.
//
// Optional feature macro: FETCH_UNIT_INSTR_CNT_EN
//   defined   : instr_count counts low-byte captures and saturates at 16'hFFFF
//   undefined : instr_count is tied to 16'h0000
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   data_in      memory read data (DW bits)
//   load_ir      capture one instruction byte this cycle
//   pc_inc       increment PC (modulo 2^AW)
//   load_pc      load PC from the IR address field (wins over pc_inc)
//   halt         stop the machine; halted stays set until reset
//   fetch        address select: 1 = pc, 0 = ir_addr
//   opcode       top three IR bits
//   ir_addr      low AW IR bits (operand / jump address)
//   pc           current program counter
//   addr         memory address, combinational from fetch/pc/ir_addr
//   instr_valid  a complete instruction is held in the IR
//   halted       machine halted
//   instr_count  retired-fetch counter
module fetch_unit #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          load_ir,
  input  logic          pc_inc,
  input  logic          load_pc,
  input  logic          halt,
  input  logic          fetch,
  output logic [2:0]    opcode,
  output logic [AW-1:0] ir_addr,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] addr,
  output logic          instr_valid,
  output logic          halted,
  output logic [15:0]   instr_count
);

  typedef enum logic {
    BYTE_HI = 1'b0,
    BYTE_LO = 1'b1
  } byte_state_e;

  byte_state_e     state_q, state_d;
  logic [2*DW-1:0] ir_q, ir_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            freeze;

  // The halt strobe freezes the machine on its own edge as well as every
  // edge afterwards, so a HLT issued together with pc_inc never advances PC.
  assign freeze = halted_q | halt;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    halted_d = halted_q | halt;
    if (!freeze) begin
      if (load_ir) begin
        case (state_q)
          BYTE_HI: begin
            ir_d[2*DW-1:DW] = data_in;
            valid_d         = 1'b0;
            state_d         = BYTE_LO;
          end
          default: begin
            ir_d[DW-1:0] = data_in;
            valid_d      = 1'b1;
            state_d      = BYTE_HI;
          end
        endcase
      end
      // load_pc uses the IR as registered before this edge's byte capture.
      if (load_pc) begin
        pc_d = ir_q[AW-1:0];
      end else if (pc_inc) begin
        pc_d = pc_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BYTE_HI;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_UNIT_INSTR_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        capture_lo;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A low-byte capture is exactly the event that completes an instruction.
  assign capture_lo = !freeze && load_ir && (state_q == BYTE_LO);

  always_comb begin
    cnt_d = cnt_q;
    if (capture_lo) begin
      cnt_d = sat_inc16(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 16'h0000;
`endif

  assign opcode      = ir_q[2*DW-1 -: 3];
  assign ir_addr     = ir_q[AW-1:0];
  assign pc          = pc_q;
  assign addr        = fetch ? pc_q : ir_q[AW-1:0];
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized strobe
// traffic, every cycle compared against a behavioural model of the fetch
// rules kept in plain integer arithmetic.
module tb_fetch_unit;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          load_ir, pc_inc, load_pc, halt, fetch;
  logic [2:0]    opcode;
  logic [AW-1:0] ir_addr, pc, addr;
  logic          instr_valid, halted;
  logic [15:0]   instr_count;

  fetch_unit #(.AW(AW), .DW(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_ir(load_ir),
    .pc_inc(pc_inc), .load_pc(load_pc), .halt(halt), .fetch(fetch),
    .opcode(opcode), .ir_addr(ir_addr), .pc(pc), .addr(addr),
    .instr_valid(instr_valid), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state: instruction word and PC as plain integers.
  int m_pc, m_ir, m_count;
  bit m_expect_lo, m_valid, m_halted;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_count = 0;
    m_expect_lo = 0; m_valid = 0; m_halted = 0;
  endtask

  // Apply one clock edge of the fetch rules to the model.
  task automatic model_step();
    int old_ir;
    old_ir = m_ir;
    if (!(m_halted || halt)) begin
      if (load_ir) begin
        if (!m_expect_lo) begin
          m_ir = (int'(data_in) << 8) | (m_ir & 'hFF);
          m_valid = 0;
        end else begin
          m_ir = (m_ir & 'hFF00) | int'(data_in);
          m_valid = 1;
`ifdef FETCH_UNIT_INSTR_CNT_EN
          if (m_count < 65535) m_count = m_count + 1;
`endif
        end
        m_expect_lo = !m_expect_lo;
      end
      if (load_pc)     m_pc = old_ir % MOD;
      else if (pc_inc) m_pc = (m_pc + 1) % MOD;
    end
    if (halt) m_halted = 1;
  endtask

  task automatic check_all(input string tag);
    int exp_addr;
    exp_addr = fetch ? m_pc : (m_ir % MOD);
    check({tag, ".pc"},     int'(pc),          m_pc);
    check({tag, ".iraddr"}, int'(ir_addr),     m_ir % MOD);
    check({tag, ".opcode"}, int'(opcode),      m_ir / MOD);
    check({tag, ".addr"},   int'(addr),        exp_addr);
    check({tag, ".valid"},  int'(instr_valid), int'(m_valid));
    check({tag, ".halted"}, int'(halted),      int'(m_halted));
    check({tag, ".count"},  int'(instr_count), m_count);
  endtask

  task automatic idle_inputs();
    load_ir = 0; pc_inc = 0; load_pc = 0; halt = 0;
  endtask

  // Drive one cycle's strobes, clock it, then compare just after the edge.
  task automatic cycle(input string tag, input bit li, input bit pi, input bit lp,
                       input bit h, input bit f, input logic [DW-1:0] d);
    load_ir = li; pc_inc = pi; load_pc = lp; halt = h; fetch = f; data_in = d;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed in the middle of a cycle.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1;
  endtask

  task automatic load_instr(input string tag, input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    cycle(tag, 1, 0, 0, 0, 1, hi);
    cycle(tag, 1, 0, 0, 0, 1, lo);
    idle_inputs();
  endtask

  initial begin
    int exp_cnt;
    rst_n = 0; fetch = 1; data_in = '0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    check("reset.addr_const", int'(addr), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: two-byte instruction assembly
    load_instr("t1", 8'hA0, 8'h1F);
    check("t1.opcode_const", int'(opcode), 3'b101);
    check("t1.iraddr_const", int'(ir_addr), 'h001F);
    check("t1.valid_const", int'(instr_valid), 1);
    fetch = 0; #1;
    check("t1.addr_ir", int'(addr), 'h001F);

    // 2: PC wrap from 1FFF
    load_instr("t2", 8'hFF, 8'hFF);
    cycle("t2.ldpc", 0, 0, 1, 0, 1, 8'h00);
    check("t2.pc_max", int'(pc), 'h1FFF);
    cycle("t2.inc", 0, 1, 0, 0, 1, 8'h00);
    check("t2.pc_wrap", int'(pc), 0);
    check("t2.addr_pc", int'(addr), 0);

    // 3: load_pc beats pc_inc
    load_instr("t3", 8'h0A, 8'hBC);
    cycle("t3.both", 0, 1, 1, 0, 1, 8'h00);
    check("t3.pc_load_wins", int'(pc), 'h0ABC);

    // 4: halt with pc_inc, then frozen until reset
    load_instr("t4", 8'h00, 8'h05);
    cycle("t4.ldpc", 0, 0, 1, 0, 1, 8'h00);
    cycle("t4.halt", 0, 1, 0, 1, 1, 8'h00);
    check("t4.pc_hold", int'(pc), 5);
    check("t4.halted", int'(halted), 1);
    for (int i = 0; i < 10; i++)
      cycle("t4.frozen", 1'($urandom), 1'($urandom), 1'($urandom), 0, 1, 8'($urandom));
    check("t4.pc_frozen", int'(pc), 5);
    check("t4.iraddr_frozen", int'(ir_addr), 5);
    idle_inputs();
    do_reset("t4.rst");
    check("t4.pc_after_rst", int'(pc), 0);
    check("t4.halted_after_rst", int'(halted), 0);

    // 5: reset in the middle of an instruction discards the high byte
    cycle("t5.hi", 1, 0, 0, 0, 1, 8'hE0);
    idle_inputs();
    do_reset("t5.rst");
    check("t5.ir_cleared", int'(opcode), 0);
    load_instr("t5", 8'h40, 8'h02);
    check("t5.opcode", int'(opcode), 3'b010);
    check("t5.iraddr", int'(ir_addr), 'h0002);

    // 6: instruction counter after three fetches from reset
    do_reset("t6.rst");
    load_instr("t6a", 8'h11, 8'h22);
    load_instr("t6b", 8'h33, 8'h44);
    load_instr("t6c", 8'h55, 8'h66);
`ifdef FETCH_UNIT_INSTR_CNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    check("t6.count", int'(instr_count), exp_cnt);

    // Randomized traffic; halts are rare and followed by a reset later.
    for (int i = 0; i < 600; i++) begin
      bit h;
      h = ($urandom_range(0, 63) == 0);
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            h, 1'($urandom), 8'($urandom));
      if (m_halted && $urandom_range(0, 7) == 0) begin
        idle_inputs();
        do_reset("rnd.rst");
      end else if ($urandom_range(0, 99) == 0) begin
        idle_inputs();
        do_reset("rnd.rst_mid");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program counter, instruction register and address multiplexer for the 8-bit RISC core.
- Sits directly downstream of the cycle controller and consumes its registered pc_inc, load_ir, load_pc and halt strobes.
- Assembles each 16-bit instruction from two consecutive memory bytes.
- Supplies opcode to the controller and the memory address to the ROM/RAM bus.

Parameters:
- AW, 13, address width of the PC and the IR address field
- DW, 8, memory data-bus width; the instruction is 2*DW bits
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  DW  memory read data
- load_ir  in  1  controller strobe: capture one instruction byte this cycle
- pc_inc  in  1  controller strobe: increment PC
- load_pc  in  1  controller strobe: load PC from IR address field
- halt  in  1  controller strobe: stop the machine
- fetch  in  1  address select: 1 = PC, 0 = IR operand address
- opcode  out  3  ir[2*DW-1 -: 3], to controller operation input
- ir_addr  out  AW  ir[AW-1:0], operand/jump address
- pc  out  AW  current program counter
- addr  out  AW  memory address: fetch ? pc : ir_addr (combinational)
- instr_valid  out  1  full instruction held in IR
- halted  out  1  machine halted, sticky until reset
- instr_count  out  16  retired-fetch counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, ir=0, byte_sel=0 (expecting high byte)
  - instr_valid=0, halted=0, instr_count=0
  - opcode=0, ir_addr=0, addr=RESET_PC when fetch=1
- IR byte state machine, two states:
  - HI (byte_sel=0): on load_ir=1, ir[2*DW-1:DW]<=data_in, instr_valid<=0, go to LO.
  - LO (byte_sel=1): on load_ir=1, ir[DW-1:0]<=data_in, instr_valid<=1, go to HI.
  - load_ir=0: state and IR hold.
- Timing: two consecutive load_ir cycles load one instruction. instr_valid rises in the cycle after the second byte is captured and stays high until the next high-byte capture.
- PC update priority, evaluated per rising edge:
  1. halted=1 or halt=1: PC holds.
  2. load_pc=1: PC<=ir_addr (ir_addr as currently registered, before any same-edge IR update).
  3. pc_inc=1: PC<=PC+1 modulo 2^AW; 2^AW-1 wraps to 0.
  4. Otherwise PC holds.
- load_pc and pc_inc together: load_pc wins and the increment is discarded.
- halt:
  - halt=1 sets halted<=1 on that edge.
  - Once halted=1: PC, IR, byte_sel and instr_valid are frozen; load_ir, pc_inc and load_pc are ignored.
  - Only rst_n clears halted.
  - halt together with pc_inc (controller HLT sequence): PC does not increment.
- Reset during a fetch (byte_sel=1): the partial high byte is discarded, and the next load_ir is treated as a high byte.
- addr is purely combinational from fetch, pc and ir_addr, with no added latency.
- opcode and ir_addr are driven directly from IR flops, so they change on the edge that captures the relevant byte.

Optional Feature:
- Macro: FETCH_UNIT_INSTR_CNT_EN
- Defined:
  - 16-bit counter increments on every low-byte capture (the instr_valid rising event).
  - Saturates at 16'hFFFF.
  - Frozen while halted; cleared by reset.
- Undefined: counter logic is not built and instr_count is tied to 16'h0000.

Test Plan:
1. Reset then two load_ir cycles with data_in=8'hA0 then 8'h1F:
   - ir=16'hA01F, opcode=3'b101, ir_addr=13'h001F
   - instr_valid=1 from the next cycle; with fetch=0, addr=13'h001F.
2. pc=13'h1FFF, pc_inc=1 for one cycle -> pc=13'h0000 (wrap). With fetch=1, addr=13'h0000.
3. IR holds ir_addr=13'h0ABC; assert load_pc=1 and pc_inc=1 in the same cycle -> pc=13'h0ABC, not 13'h0ABD.
4. pc=13'h0005; assert halt=1 and pc_inc=1 together:
   - pc stays 13'h0005, halted=1.
   - Further load_ir/pc_inc/load_pc pulses over 10 cycles change nothing.
   - rst_n pulse -> pc=0, halted=0.
5. One load_ir with 8'hE0 (byte_sel=1), then async rst_n low mid-cycle:
   - byte_sel=0, ir=0.
   - Next two load_ir with 8'h40, 8'h02 -> ir=16'h4002, opcode=3'b010.
6. With FETCH_UNIT_INSTR_CNT_EN defined, fetch 3 instructions (6 load_ir) -> instr_count=3. Without the macro -> instr_count=0.
